serial_negator_ctrl: RTL and testbench
======================================

Name: serial_negator_ctrl

Overview:
- Sequencer for the bit-serial two's-complement negation datapath (Mealy "copy up to first 1, then invert" stage).
- Accepts a parallel WIDTH-bit word over a valid/ready handshake and serialises it LSB-first through an internal negation stage.
- Clears the stage's one-bit state before each word, gates its enable for exactly WIDTH cycles, and reassembles the result.
- Presents the result over a second valid/ready handshake.

Parameters:
- WIDTH, 8, word width in bits (legal range 2..32).

Ports:
- CLK  input  1  clock; all registers update on the falling edge of CLK.
- Reset  input  1  asynchronous, active-low reset.
- In_Valid  input  1  Din is valid.
- In_Ready  output  1  controller can accept a word.
- Din  input  WIDTH  operand.
- Out_Valid  output  1  Dout holds a completed result.
- Out_Ready  input  1  consumer accepts Dout.
- Dout  output  WIDTH  negated operand, -Din mod 2^WIDTH.
- Busy  output  1  high in any state other than IDLE.
- Ovf  output  1  present only with OVF_DETECT_EN; see Optional Feature.

Behaviour:
- Reset low, asynchronously:
  - state=IDLE; shift register, result register and bit counter cleared to 0; negation state bit s cleared to 0.
  - Out_Valid=0, Busy=0, Dout=0, In_Ready=0.
  - Handshakes are ignored while Reset is low.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - In_Ready=1 (only when Reset is high).
  - On a falling edge with In_Valid=1: load sh=Din, cnt=0, s=0, res=0; go to SHIFT.
- SHIFT:
  - In_Ready=0, Out_Valid=0.
  - Each edge, with x=sh[0]:
    - n = s ? ~x : x
    - s <= s | x
    - res <= {n, res[WIDTH-1:1]}
    - sh <= sh>>1
    - cnt <= cnt+1
  - On the edge where cnt==WIDTH-1, go to DONE.
  - SHIFT lasts exactly WIDTH edges.
- DONE:
  - Out_Valid=1, Dout=res, held stable.
  - On an edge with Out_Ready=1: go to IDLE; Out_Valid drops.
- Latency: Out_Valid rises WIDTH falling edges after the input acceptance edge. Throughput is one word per WIDTH+2 edges with Out_Ready held high.
- No overlap: no new word is accepted during SHIFT or DONE. In_Valid there is ignored and must be held by the producer.
- Out_Ready while not in DONE: ignored.
- Dout when Out_Valid=0: holds the last result (0 after reset) and is not meaningful.
- cnt is $clog2(WIDTH)+1 bits wide; it never wraps within a word.
- Reset mid-SHIFT or mid-DONE: word discarded, return to IDLE. The first word after release must be unaffected (s cleared).
- Arithmetic: Din=0 -> 0. Din=2^(WIDTH-1) -> itself (no representable negation).

Optional Feature:
- Macro: SERIAL_NEGATOR_OVF_DETECT_EN.
- Defined:
  - Ovf port exists.
  - An ovf register is loaded at acceptance with (Din == 1 followed by WIDTH-1 zeros).
  - Ovf = ovf & Out_Valid.
  - ovf is cleared on reset and on the output handshake.
- Undefined: no Ovf port and no ovf register; all other behaviour is identical.

Test Plan:
- WIDTH=8, Out_Ready=1, Din=0x05 -> Dout=0xFB; Out_Valid rises exactly 8 edges after acceptance; Busy high throughout.
- Din=0x00 -> 0x00; Din=0x01 -> 0xFF; Din=0xFF -> 0x01; Din=0x7F -> 0x81 (Ovf=0 with macro).
- Din=0x80 -> Dout=0x80; Ovf=1 with macro only during Out_Valid; port absent without macro.
- Out_Ready=0 for 5 edges in DONE -> Dout=0xFB and Out_Valid stay stable. In_Ready=0; a pulsed In_Valid with Din=0x33 is not accepted.
- Reset pulsed low at bit 3 of Din=0x06 -> Out_Valid=0, Busy=0 immediately. After release, Din=0x0C -> 0xF4.
- Back-to-back Din=0x10 then 0xF0, In_Valid and Out_Ready held high -> outputs 0xF0 then 0x10. In_Ready returns 1 one edge after each output handshake.

Source files
------------

// File: rtl/serial_negator_ctrl.sv
// serial_negator_ctrl: LSB-first bit-serial two's-complement negator with valid/ready in and out.
// Define SERIAL_NEGATOR_OVF_DETECT_EN to add the Ovf output (operand was the most negative value).
module serial_negator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Din,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Dout,
    output logic             Busy
`ifdef SERIAL_NEGATOR_OVF_DETECT_EN
    ,
    output logic             Ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh, res, dout_q;
    logic [CW-1:0]    cnt;
    logic             s, x, n, last, accept, retire;

    assign x      = sh[0];
    assign n      = s ? ~x : x;
    assign last   = cnt == CW'(WIDTH - 1);
    assign accept = state == IDLE && In_Valid;
    assign retire = state == DONE && Out_Ready;

    always_ff @(negedge CLK or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? SHIFT : IDLE;
            SHIFT:   state_nx = last ? DONE : SHIFT;
            DONE:    state_nx = retire ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        In_Ready  = Reset && state == IDLE;
        Out_Valid = state == DONE;
        Busy      = state != IDLE;
        Dout      = dout_q;
    end

    // Copy bits up to and including the first 1, invert every bit after it.
    always_ff @(negedge CLK or negedge Reset) begin
        if (!Reset) begin
            sh     <= '0;
            res    <= '0;
            dout_q <= '0;
            cnt    <= '0;
            s      <= 1'b0;
        end else if (accept) begin
            sh  <= Din;
            res <= '0;
            cnt <= '0;
            s   <= 1'b0;
        end else if (state == SHIFT) begin
            s   <= s | x;
            res <= {n, res[WIDTH-1:1]};
            sh  <= sh >> 1;
            cnt <= cnt + 1'b1;
            if (last) dout_q <= {n, res[WIDTH-1:1]};
        end
    end

`ifdef SERIAL_NEGATOR_OVF_DETECT_EN
    logic ovf;

    always_ff @(negedge CLK or negedge Reset) begin
        if (!Reset)      ovf <= 1'b0;
        else if (accept) ovf <= Din == {1'b1, {(WIDTH-1){1'b0}}};
        else if (retire) ovf <= 1'b0;
    end

    assign Ovf = ovf & Out_Valid;
`endif
endmodule

// File: tb/tb_serial_negator_ctrl.sv
// tb_serial_negator_ctrl: directed and random words checked against an arithmetic negation model.
module tb_serial_negator_ctrl;
    localparam int W = 8;

    logic         CLK = 1'b0, Reset = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b0;
    logic         In_Ready, Out_Valid, Busy;
    logic [W-1:0] Din = '0, Dout;
`ifdef SERIAL_NEGATOR_OVF_DETECT_EN
    logic         Ovf;
`endif
    int vectors = 0, miscompares = 0;
    bit hold = 1'b0;

    always #5 CLK = ~CLK;

    serial_negator_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready), .Din(Din),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Dout(Dout), .Busy(Busy)
`ifdef SERIAL_NEGATOR_OVF_DETECT_EN
        , .Ovf(Ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registers move on falling edges; stimulus and sampling sit just after the rising edge.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] neg_ref(input logic [W-1:0] d);
        return W'((1 << W) - int'(d));
    endfunction

    task automatic run_word(input logic [W-1:0] d, input int stall);
        int n = 0;
        logic [W-1:0] exp = neg_ref(d);
        while (!In_Ready && n < 50) begin
            tick;
            n++;
        end
        chk("in_ready_before", 32'(In_Ready), 1);
        In_Valid  = 1'b1;
        Din       = d;
        Out_Ready = stall == 0;
        tick;
        if (!hold) In_Valid = 1'b0;
        chk("busy_after_accept", 32'(Busy), 1);
        chk("in_ready_shift", 32'(In_Ready), 0);
        for (int i = 1; i <= W; i++) begin
            tick;
            chk("out_valid_latency", 32'(Out_Valid), 32'(i == W));
        end
        chk("dout", 32'(Dout), 32'(exp));
        chk("busy_done", 32'(Busy), 1);
`ifdef SERIAL_NEGATOR_OVF_DETECT_EN
        chk("ovf", 32'(Ovf), 32'(d == W'(1 << (W - 1))));
`endif
        for (int k = 0; k < stall; k++) begin
            In_Valid = k == 0;
            Din      = 8'h33;
            tick;
            chk("dout_stall", 32'(Dout), 32'(exp));
            chk("out_valid_stall", 32'(Out_Valid), 1);
            chk("in_ready_stall", 32'(In_Ready), 0);
        end
        In_Valid  = hold;
        Din       = d;
        Out_Ready = 1'b1;
        tick;
        chk("out_valid_drop", 32'(Out_Valid), 0);
        chk("in_ready_return", 32'(In_Ready), 1);
        chk("dout_hold", 32'(Dout), 32'(exp));
`ifdef SERIAL_NEGATOR_OVF_DETECT_EN
        chk("ovf_idle", 32'(Ovf), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick;
        tick;
        chk("rst_out_valid", 32'(Out_Valid), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_in_ready", 32'(In_Ready), 0);
        chk("rst_dout", 32'(Dout), 0);
        Reset = 1'b1;
        tick;
        chk("idle_in_ready", 32'(In_Ready), 1);
        chk("idle_busy", 32'(Busy), 0);

        run_word(8'h05, 0);
        run_word(8'h00, 0);
        run_word(8'h01, 0);
        run_word(8'hFF, 0);
        run_word(8'h7F, 0);
        run_word(8'h80, 0);
        run_word(8'h05, 5);

        Din      = 8'h06;
        In_Valid = 1'b1;
        tick;
        In_Valid = 1'b0;
        repeat (3) tick;
        chk("busy_pre_reset", 32'(Busy), 1);
        Reset = 1'b0;
        #1;
        chk("mid_reset_out_valid", 32'(Out_Valid), 0);
        chk("mid_reset_busy", 32'(Busy), 0);
        chk("mid_reset_in_ready", 32'(In_Ready), 0);
        tick;
        Reset = 1'b1;
        tick;
        run_word(8'h0C, 0);

        hold = 1'b1;
        run_word(8'h10, 0);
        run_word(8'hF0, 0);
        hold     = 1'b0;
        In_Valid = 1'b0;

        for (int r = 0; r < 16; r++) run_word(W'($urandom), int'($urandom_range(0, 2)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
